// File: rtl/step_sequencer_pkg.sv
// Shared definitions for the step sequencer: FSM state codes and the sizing check.
// Imported by step_sequencer and onehot_decode.
package step_sequencer_pkg;

   localparam logic [1:0] SEQ_IDLE  = 2'd0;
   localparam logic [1:0] SEQ_RUN   = 2'd1;
   localparam logic [1:0] SEQ_PAUSE = 2'd2;

   // True when the step index can hold every position and there are at least two positions.
   function automatic bit sizing_ok(input int num_steps, input int step_w);
      return (num_steps >= 2) && ((64'd1 << step_w) >= 64'(num_steps));
   endfunction

endpackage

// File: rtl/step_sequencer_onehot_decode.sv
// Index-to-one-hot decoder driving the LED bank; all outputs low when en is low.
// Kept separate so the LED width can be reused by other boards.
module onehot_decode
   import step_sequencer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [WIDTH-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (en && (idx == IDX_W'(i))) begin
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/step_sequencer.sv
// One-hot LED step sequencer advanced by divider ticks, with go/stop control and pass counting.
// Define SEQ_BOUNCE_EN for ping-pong motion instead of wrapping.
module step_sequencer
   import step_sequencer_pkg::*;
#(
   parameter int NUM_STEPS = 8,
   parameter int STEP_W    = 3,
   parameter int LOOPS     = 0,
   parameter int LOOP_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 go,
   input  logic                 stop,
   input  logic                 dir,
   output logic [NUM_STEPS-1:0] leds,
   output logic [STEP_W-1:0]    step,
   output logic                 running,
   output logic                 done
);

   localparam logic [STEP_W-1:0] LAST      = STEP_W'(NUM_STEPS - 1);
   localparam logic [LOOP_W-1:0] LOOPS_V   = LOOP_W'(LOOPS);
   localparam bit                AUTO_STOP = (LOOPS != 0);

   generate
      if (!sizing_ok(NUM_STEPS, STEP_W)) begin : g_bad_sizing
         $error("step_sequencer: NUM_STEPS must be >= 2 and fit in STEP_W bits");
      end
   endgenerate

   logic [1:0]           state, state_nx;
   logic [STEP_W-1:0]    step_nx, step_adv;
   logic [LOOP_W-1:0]    pass_cnt, pass_nx, pass_inc;
   logic                 done_nx;
   logic                 at_end;
   logic                 down;
   logic [NUM_STEPS-1:0] leds_nx;

`ifdef SEQ_BOUNCE_EN
   // Direction is latched on go from IDLE and then owned by the bounce logic.
   logic down_q, down_nx;
   assign down = down_q;
`else
   assign down = dir;
`endif

   assign at_end   = down ? (step == '0) : (step == LAST);
   assign step_adv = down ? (step - 1'b1) : (step + 1'b1);
   assign pass_inc = pass_cnt + 1'b1;

   always_comb begin
      state_nx = state;
      step_nx  = step;
      pass_nx  = pass_cnt;
      done_nx  = 1'b0;
`ifdef SEQ_BOUNCE_EN
      down_nx  = down_q;
`endif
      case (state)
         SEQ_IDLE: begin
            if (!stop && go) begin
               state_nx = SEQ_RUN;
               step_nx  = dir ? LAST : '0;
               pass_nx  = '0;
`ifdef SEQ_BOUNCE_EN
               down_nx  = dir;
`endif
            end
         end
         SEQ_RUN: begin
            if (stop) begin
               state_nx = SEQ_PAUSE;
            end else if (tick) begin
               if (at_end) begin
                  pass_nx = pass_inc;
                  if (AUTO_STOP && (pass_inc == LOOPS_V)) begin
                     state_nx = SEQ_IDLE;
                     step_nx  = '0;
                     done_nx  = 1'b1;
                  end else begin
`ifdef SEQ_BOUNCE_EN
                     // Turn around: step back away from the end just shown.
                     down_nx = !down_q;
                     step_nx = down_q ? (step + 1'b1) : (step - 1'b1);
`else
                     step_nx = down ? LAST : '0;
`endif
                  end
               end else begin
                  step_nx = step_adv;
               end
            end
         end
         SEQ_PAUSE: begin
            if (stop) begin
               state_nx = SEQ_IDLE;
               step_nx  = '0;
            end else if (go) begin
               state_nx = SEQ_RUN;
            end
         end
         default: begin
            state_nx = SEQ_IDLE;
            step_nx  = '0;
         end
      endcase
   end

   // Decode the next step so leds and step land on the same edge.
   onehot_decode #(
      .WIDTH (NUM_STEPS),
      .IDX_W (STEP_W)
   ) u_decode (
      .idx    (step_nx),
      .en     (state_nx != SEQ_IDLE),
      .onehot (leds_nx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= SEQ_IDLE;
         step     <= '0;
         leds     <= '0;
         running  <= 1'b0;
         done     <= 1'b0;
         pass_cnt <= '0;
`ifdef SEQ_BOUNCE_EN
         down_q   <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         step     <= step_nx;
         leds     <= leds_nx;
         running  <= (state_nx == SEQ_RUN);
         done     <= done_nx;
         pass_cnt <= pass_nx;
`ifdef SEQ_BOUNCE_EN
         down_q   <= down_nx;
`endif
      end
   end

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer (NUM_STEPS = 4) with an integer reference model.
// Build with SEQ_BOUNCE_EN defined to exercise ping-pong mode (LOOPS = 0 then).
module tb_step_sequencer;

   localparam int N = 4;
`ifdef SEQ_BOUNCE_EN
   localparam int LOOPS = 0;
`else
   localparam int LOOPS = 2;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         tick = 1'b0;
   logic         go = 1'b0;
   logic         stop = 1'b0;
   logic         dir = 1'b0;
   logic [N-1:0] leds;
   logic [1:0]   step;
   logic         running;
   logic         done;

   int n_cmp = 0;
   int n_bad = 0;

   step_sequencer #(
      .NUM_STEPS (N),
      .STEP_W    (2),
      .LOOPS     (LOOPS),
      .LOOP_W    (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .go      (go),
      .stop    (stop),
      .dir     (dir),
      .leds    (leds),
      .step    (step),
      .running (running),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 = idle, 1 = run, 2 = pause; position as plain integer.
   int m_mode = 0;
   int m_pos = 0;
   int m_passes = 0;
   int m_move = 1;
   bit m_done = 1'b0;

   always @(posedge clk) begin
      int delta, nxt;
      m_done = 1'b0;
      if (rst) begin
         m_mode = 0; m_pos = 0; m_passes = 0; m_move = 1;
      end else if (m_mode == 0) begin
         if (!stop && go) begin
            m_mode = 1; m_pos = dir ? N - 1 : 0; m_passes = 0; m_move = dir ? -1 : 1;
         end
      end else if (m_mode == 1) begin
         if (stop) m_mode = 2;
         else if (tick) begin
`ifdef SEQ_BOUNCE_EN
            delta = m_move;
`else
            delta = dir ? -1 : 1;
`endif
            nxt = m_pos + delta;
            if (nxt < 0 || nxt >= N) begin
               m_passes++;
               if (LOOPS != 0 && m_passes == LOOPS) begin
                  m_mode = 0; m_pos = 0; m_done = 1'b1;
               end else begin
`ifdef SEQ_BOUNCE_EN
                  m_move = -m_move;
                  m_pos = m_pos - delta;
`else
                  m_pos = (nxt + N) % N;
`endif
               end
            end else begin
               m_pos = nxt;
            end
         end
      end else begin
         if (stop) begin m_mode = 0; m_pos = 0; end
         else if (go) m_mode = 1;
      end
   end

   task automatic step_clk(input bit g, input bit s, input bit t);
      go = g; stop = s; tick = t;
      @(posedge clk);
      #1;
      go = 1'b0; stop = 1'b0; tick = 1'b0;
   endtask

   task automatic tick_period();
      repeat (4) step_clk(1'b0, 1'b0, 1'b0);
      step_clk(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step_clk(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      n_cmp++; if (leds !== 4'b0000) begin n_bad++; $display("FAIL reset_leds got=%b want=0000", leds); end
      n_cmp++; if (step !== 2'd0) begin n_bad++; $display("FAIL reset_step got=%0d want=0", step); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running got=%b want=0", running); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
   endtask

`ifndef SEQ_BOUNCE_EN
   task automatic test_ascend_and_done();
      logic [3:0] want_leds [7];
      logic [1:0] want_step [7];
      want_leds = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      want_step = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      dir = 1'b0;
      step_clk(1'b1, 1'b0, 1'b1);
      n_cmp++; if (leds !== 4'b0001) begin n_bad++; $display("FAIL asc_start_leds got=%b want=0001", leds); end
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL asc_running got=%b want=1", running); end
      for (int i = 0; i < 7; i++) begin
         tick_period();
         n_cmp++; if (leds !== want_leds[i]) begin n_bad++; $display("FAIL asc_leds tick=%0d got=%b want=%b", i, leds, want_leds[i]); end
         n_cmp++; if (step !== want_step[i]) begin n_bad++; $display("FAIL asc_step tick=%0d got=%0d want=%0d", i, step, want_step[i]); end
         n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL asc_early_done tick=%0d got=%b want=0", i, done); end
      end
      tick_period();
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL done_pulse got=%b want=1", done); end
      n_cmp++; if (leds !== 4'b0000) begin n_bad++; $display("FAIL done_leds got=%b want=0000", leds); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL done_running got=%b want=0", running); end
      step_clk(1'b0, 1'b0, 1'b1);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_width got=%b want=0", done); end
      n_cmp++; if (leds !== 4'b0000) begin n_bad++; $display("FAIL done_idle_leds got=%b want=0000", leds); end
   endtask

   task automatic test_stop_pause();
      dir = 1'b0;
      step_clk(1'b1, 1'b0, 1'b0);
      tick_period(); tick_period();
      repeat (4) step_clk(1'b0, 1'b0, 1'b0);
      step_clk(1'b0, 1'b1, 1'b1);
      n_cmp++; if (step !== 2'd2) begin n_bad++; $display("FAIL pause_step got=%0d want=2", step); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL pause_running got=%b want=0", running); end
      n_cmp++; if (leds !== 4'b0100) begin n_bad++; $display("FAIL pause_leds got=%b want=0100", leds); end
      tick_period();
      n_cmp++; if (step !== 2'd2) begin n_bad++; $display("FAIL pause_tick_ignored got=%0d want=2", step); end
      step_clk(1'b1, 1'b0, 1'b0);
      n_cmp++; if (running !== 1'b1 || step !== 2'd2) begin n_bad++; $display("FAIL resume got=%b/%0d want=1/2", running, step); end
      tick_period();
      n_cmp++; if (step !== 2'd3) begin n_bad++; $display("FAIL resume_tick got=%0d want=3", step); end
      tick_period(); tick_period(); tick_period();
      n_cmp++; if (step !== 2'd2 || running !== 1'b1) begin n_bad++; $display("FAIL rerun_step got=%0d/%b want=2/1", step, running); end
      step_clk(1'b0, 1'b1, 1'b0);
      step_clk(1'b0, 1'b1, 1'b0);
      n_cmp++; if (leds !== 4'b0000 || step !== 2'd0) begin n_bad++; $display("FAIL abort got=%b/%0d want=0000/0", leds, step); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL abort_running got=%b want=0", running); end
   endtask

   task automatic test_descend();
      logic [1:0] want_step [6];
      want_step = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
      dir = 1'b1;
      step_clk(1'b1, 1'b0, 1'b0);
      n_cmp++; if (step !== 2'd3 || leds !== 4'b1000) begin n_bad++; $display("FAIL desc_start got=%0d/%b want=3/1000", step, leds); end
      for (int i = 0; i < 6; i++) begin
         tick_period();
         n_cmp++; if (step !== want_step[i]) begin n_bad++; $display("FAIL desc_step tick=%0d got=%0d want=%0d", i, step, want_step[i]); end
      end
      dir = 1'b0;
      tick_period();
      n_cmp++; if (step !== 2'd2 || leds !== 4'b0100) begin n_bad++; $display("FAIL dir_toggle got=%0d/%b want=2/0100", step, leds); end
      step_clk(1'b0, 1'b1, 1'b0);
      step_clk(1'b0, 1'b1, 1'b0);
   endtask
`else
   task automatic test_bounce();
      logic [1:0] want_step [7];
      want_step = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
      dir = 1'b0;
      step_clk(1'b1, 1'b0, 1'b0);
      n_cmp++; if (step !== 2'd0 || leds !== 4'b0001) begin n_bad++; $display("FAIL bounce_start got=%0d/%b want=0/0001", step, leds); end
      for (int i = 0; i < 7; i++) begin
         tick_period();
         n_cmp++; if (step !== want_step[i]) begin n_bad++; $display("FAIL bounce_step tick=%0d got=%0d want=%0d", i, step, want_step[i]); end
      end
      step_clk(1'b1, 1'b1, 1'b0);
      n_cmp++; if (running !== 1'b0 || step !== 2'd1) begin n_bad++; $display("FAIL bounce_gostop got=%b/%0d want=0/1", running, step); end
      dir = 1'b1;
      step_clk(1'b1, 1'b0, 1'b0);
      tick_period();
      n_cmp++; if (step !== 2'd2) begin n_bad++; $display("FAIL bounce_dir_ignored got=%0d want=2", step); end
      step_clk(1'b0, 1'b1, 1'b0);
      step_clk(1'b0, 1'b1, 1'b0);
      n_cmp++; if (leds !== 4'b0000) begin n_bad++; $display("FAIL bounce_abort got=%b want=0000", leds); end
   endtask
`endif

   task automatic test_random();
      logic [3:0] want_leds;
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 15) == 0) dir = ~dir;
         step_clk($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
         rst = 1'b0;
         want_leds = (m_mode == 0) ? 4'b0000 : 4'(1 << m_pos);
         n_cmp++; if (leds !== want_leds) begin n_bad++; $display("FAIL rand_leds cyc=%0d got=%b want=%b", c, leds, want_leds); end
         n_cmp++; if (step !== 2'(m_pos)) begin n_bad++; $display("FAIL rand_step cyc=%0d got=%0d want=%0d", c, step, m_pos); end
         n_cmp++; if (running !== (m_mode == 1)) begin n_bad++; $display("FAIL rand_running cyc=%0d got=%b want=%b", c, running, m_mode == 1); end
         n_cmp++; if (done !== m_done) begin n_bad++; $display("FAIL rand_done cyc=%0d got=%b want=%b", c, done, m_done); end
      end
   endtask

   initial begin
      test_reset();
`ifndef SEQ_BOUNCE_EN
      test_ascend_and_done();
      test_stop_pause();
      test_descend();
`else
      test_bounce();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
